roundrobin: RTL and testbench

//  Weighted round-robin scheduler draining four virtual-channel FIFOs into one 4-bit output stream.

---
 rtl/roundrobin_pkg.sv | 21 ++
 rtl/rr_next_ch.sv | 25 ++
 rtl/roundrobin.sv | 134 +++++++++++++
 tb/tb_roundrobin.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/roundrobin_pkg.sv
// Shared types and constants for the weighted round-robin VC scheduler.
package roundrobin_pkg;

    typedef logic [1:0] vc_idx_t;
    typedef logic [3:0] data_t;

    localparam vc_idx_t VCHANEL0 = 2'b00;
    localparam vc_idx_t VCHANEL1 = 2'b01;
    localparam vc_idx_t VCHANEL2 = 2'b10;
    localparam vc_idx_t VCHANEL3 = 2'b11;

    localparam data_t   INACTIVE = 4'b0000;

    localparam int unsigned NUM_VC = 4;

    // Cyclic channel index arithmetic; wraps naturally at 2 bits.
    function automatic vc_idx_t vc_add(input vc_idx_t base, input vc_idx_t off);
        return vc_idx_t'(base + off);
    endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Rotating priority finder: first non-empty channel after start_i, with
// start_i itself searched last.
module rr_next_ch
    import roundrobin_pkg::*;
(
    input  logic [3:0] empty_i,
    input  vc_idx_t    start_i,
    output vc_idx_t    next_o,
    output logic       found_o
);

    // Walk offsets from lowest priority (4 == start itself) to highest (1)
    // so the highest-priority hit is the one that sticks.
    always_comb begin
        next_o  = start_i;
        found_o = 1'b0;
        for (int unsigned off = NUM_VC; off >= 1; off--) begin
            if (!empty_i[vc_add(start_i, vc_idx_t'(off))]) begin
                next_o  = vc_add(start_i, vc_idx_t'(off));
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/roundrobin.sv
// Weighted round-robin scheduler draining four first-word-fall-through VC
// FIFOs into one registered 4-bit output stream.
module roundrobin
    import roundrobin_pkg::*;
#(
    parameter int unsigned WEIGHT0 = 4,
    parameter int unsigned WEIGHT1 = 3,
    parameter int unsigned WEIGHT2 = 2,
    parameter int unsigned WEIGHT3 = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [3:0] out_vchanel0,
    input  logic [3:0] out_vchanel1,
    input  logic [3:0] out_vchanel2,
    input  logic [3:0] out_vchanel3,
    input  logic       empty_vchanel0,
    input  logic       empty_vchanel1,
    input  logic       empty_vchanel2,
    input  logic       empty_vchanel3,
    output logic       pop_vchanel0,
    output logic       pop_vchanel1,
    output logic       pop_vchanel2,
    output logic       pop_vchanel3,
    output logic [3:0] out_wgthd_rndrobin,
    output logic       valid_out,
    output logic [1:0] arbiter
);

    generate
        if (WEIGHT0 < 1 || WEIGHT0 > 15 || WEIGHT1 < 1 || WEIGHT1 > 15 ||
            WEIGHT2 < 1 || WEIGHT2 > 15 || WEIGHT3 < 1 || WEIGHT3 > 15) begin : g_bad_weight
            $fatal(1, "roundrobin: every WEIGHTn must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] W0 = 4'(WEIGHT0);
    localparam logic [3:0] W1 = 4'(WEIGHT1);
    localparam logic [3:0] W2 = 4'(WEIGHT2);
    localparam logic [3:0] W3 = 4'(WEIGHT3);

    data_t      head [NUM_VC];
    logic [3:0] empty_v;

    assign head[0] = out_vchanel0;
    assign head[1] = out_vchanel1;
    assign head[2] = out_vchanel2;
    assign head[3] = out_vchanel3;
    assign empty_v = {empty_vchanel3, empty_vchanel2, empty_vchanel1, empty_vchanel0};

    vc_idx_t    cur_q, cur_d;
    logic [3:0] credit_q, credit_d;
    data_t      out_q, out_d;
    vc_idx_t    arb_q, arb_d;
    logic       valid_q, valid_d;

    logic [3:0] cur_weight;
    vc_idx_t    nxt_ch;
    logic       nxt_found;
    logic       cont;
    logic       grant;
    vc_idx_t    gnt_ch;

    rr_next_ch u_next_ch (
        .empty_i (empty_v),
        .start_i (cur_q),
        .next_o  (nxt_ch),
        .found_o (nxt_found)
    );

    always_comb begin
        cur_weight = W0;
        case (cur_q)
            VCHANEL0: cur_weight = W0;
            VCHANEL1: cur_weight = W1;
            VCHANEL2: cur_weight = W2;
            VCHANEL3: cur_weight = W3;
            default:  cur_weight = W0;
        endcase
    end

    // Pops are gated by rst as well so nothing drains while reset is held.
    assign cont   = rst && enb && !empty_v[cur_q] && (credit_q < cur_weight);
    assign grant  = rst && enb && (cont || nxt_found);
    assign gnt_ch = cont ? cur_q : nxt_ch;

    always_comb begin
        cur_d        = cur_q;
        credit_d     = credit_q;
        out_d        = out_q;
        arb_d        = arb_q;
        valid_d      = 1'b0;
        pop_vchanel0 = 1'b0;
        pop_vchanel1 = 1'b0;
        pop_vchanel2 = 1'b0;
        pop_vchanel3 = 1'b0;
        if (grant) begin
            case (gnt_ch)
                VCHANEL0: pop_vchanel0 = 1'b1;
                VCHANEL1: pop_vchanel1 = 1'b1;
                VCHANEL2: pop_vchanel2 = 1'b1;
                VCHANEL3: pop_vchanel3 = 1'b1;
                default:  pop_vchanel0 = 1'b0;
            endcase
            out_d    = head[gnt_ch];
            arb_d    = gnt_ch;
            valid_d  = 1'b1;
            cur_d    = gnt_ch;
            credit_d = cont ? credit_q + 4'd1 : 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q    <= VCHANEL0;
            credit_q <= '0;
            out_q    <= INACTIVE;
            arb_q    <= VCHANEL0;
            valid_q  <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            credit_q <= credit_d;
            out_q    <= out_d;
            arb_q    <= arb_d;
            valid_q  <= valid_d;
        end
    end

    assign out_wgthd_rndrobin = out_q;
    assign arbiter            = arb_q;
    assign valid_out          = valid_q;

endmodule

// File: tb/tb_roundrobin.sv
// Directed self-checking bench for the weighted round-robin scheduler
// (weights 4,3,2,1; VCn head word is n+1).
module tb_roundrobin;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic [3:0] out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3;
    logic       empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3;
    logic       pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3;
    logic [3:0] out_wgthd_rndrobin;
    logic       valid_out;
    logic [1:0] arbiter;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    roundrobin #(
        .WEIGHT0(4),
        .WEIGHT1(3),
        .WEIGHT2(2),
        .WEIGHT3(1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enb                (enb),
        .out_vchanel0       (out_vchanel0),
        .out_vchanel1       (out_vchanel1),
        .out_vchanel2       (out_vchanel2),
        .out_vchanel3       (out_vchanel3),
        .empty_vchanel0     (empty_vchanel0),
        .empty_vchanel1     (empty_vchanel1),
        .empty_vchanel2     (empty_vchanel2),
        .empty_vchanel3     (empty_vchanel3),
        .pop_vchanel0       (pop_vchanel0),
        .pop_vchanel1       (pop_vchanel1),
        .pop_vchanel2       (pop_vchanel2),
        .pop_vchanel3       (pop_vchanel3),
        .out_wgthd_rndrobin (out_wgthd_rndrobin),
        .valid_out          (valid_out),
        .arbiter            (arbiter)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_empty(input logic [3:0] e);
        {empty_vchanel3, empty_vchanel2, empty_vchanel1, empty_vchanel0} = e;
    endtask

    // Called at a negedge: one granted cycle from channel g.
    task automatic serve(input logic [3:0] e, input logic [1:0] g, input string tag);
        logic [3:0] pop_exp;
        pop_exp = 4'b0001 << g;
        set_empty(e);
        enb = 1'b1;
        #1;
        chk({tag, ".pop"}, {4'h0, pop_vchanel3, pop_vchanel2, pop_vchanel1, pop_vchanel0}, {4'h0, pop_exp});
        @(posedge clk);
        #1;
        chk({tag, ".arb"}, {6'h0, arbiter}, {6'h0, g});
        chk({tag, ".out"}, {4'h0, out_wgthd_rndrobin}, {4'h0, 4'(g) + 4'd1});
        chk({tag, ".vld"}, {7'h0, valid_out}, 8'h01);
        @(negedge clk);
    endtask

    // Called at a negedge: a cycle with no grant; out/arbiter must hold.
    task automatic idle(input logic [3:0] e, input logic en, input logic [3:0] out_hold,
                        input logic [1:0] arb_hold, input string tag);
        set_empty(e);
        enb = en;
        #1;
        chk({tag, ".pop"}, {4'h0, pop_vchanel3, pop_vchanel2, pop_vchanel1, pop_vchanel0}, 8'h00);
        @(posedge clk);
        #1;
        chk({tag, ".arb"}, {6'h0, arbiter}, {6'h0, arb_hold});
        chk({tag, ".out"}, {4'h0, out_wgthd_rndrobin}, {4'h0, out_hold});
        chk({tag, ".vld"}, {7'h0, valid_out}, 8'h00);
        @(negedge clk);
    endtask

    logic [1:0] full_seq [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [3:0] e_drain  [8]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0101,
                                  4'b0101, 4'b0101, 4'b0101, 4'b0100};
    logic [1:0] g_drain  [8]  = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0};

    initial begin
        out_vchanel0 = 4'd1;
        out_vchanel1 = 4'd2;
        out_vchanel2 = 4'd3;
        out_vchanel3 = 4'd4;
        rst = 1'b0;
        enb = 1'b1;
        set_empty(4'b0000);

        #1;
        chk("rst.out", {4'h0, out_wgthd_rndrobin}, 8'h00);
        chk("rst.arb", {6'h0, arbiter}, 8'h00);
        chk("rst.vld", {7'h0, valid_out}, 8'h00);
        chk("rst.pop", {4'h0, pop_vchanel3, pop_vchanel2, pop_vchanel1, pop_vchanel0}, 8'h00);
        @(negedge clk);
        chk("rst_hold.vld", {7'h0, valid_out}, 8'h00);
        rst = 1'b1;

        // All channels full: weighted rotation twice round.
        for (int i = 0; i < 20; i++)
            serve(4'b0000, full_seq[i % 10], $sformatf("full[%0d]", i));

        // Lone VC2 served past its weight.
        for (int i = 0; i < 8; i++)
            serve(4'b1011, 2'd2, $sformatf("lone2[%0d]", i));

        // VC2 empty throughout; VC0 runs dry after two words then refills.
        for (int i = 0; i < 8; i++)
            serve(e_drain[i], g_drain[i], $sformatf("drain[%0d]", i));

        for (int i = 0; i < 5; i++)
            idle(4'b1111, 1'b1, 4'd1, 2'd0, $sformatf("allempty[%0d]", i));
        serve(4'b0111, 2'd3, "vc3_wake");

        // Freeze for three cycles after VC0's second word.
        serve(4'b0000, 2'd0, "enb.w1");
        serve(4'b0000, 2'd0, "enb.w2");
        for (int i = 0; i < 3; i++)
            idle(4'b0000, 1'b0, 4'd1, 2'd0, $sformatf("frozen[%0d]", i));
        serve(4'b0000, 2'd0, "enb.w3");
        serve(4'b0000, 2'd0, "enb.w4");
        serve(4'b0000, 2'd1, "enb.vc1");

        // Asynchronous reset in the middle of a stream.
        rst = 1'b0;
        #1;
        chk("midrst.out", {4'h0, out_wgthd_rndrobin}, 8'h00);
        chk("midrst.arb", {6'h0, arbiter}, 8'h00);
        chk("midrst.vld", {7'h0, valid_out}, 8'h00);
        chk("midrst.pop", {4'h0, pop_vchanel3, pop_vchanel2, pop_vchanel1, pop_vchanel0}, 8'h00);
        @(posedge clk);
        #1;
        chk("midrst_edge.vld", {7'h0, valid_out}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        serve(4'b0000, 2'd0, "post_rst");
        serve(4'b0000, 2'd0, "post_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
